// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: strobes bit_done on the last clock of every UART bit.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_done = !clear && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear || bit_done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_wb.sv
// UART transmitter with a Wishbone pipelined slave front end (8N1, LSB first).
module uart_tx_wb
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  output logic       stall_o,
  output logic       tx_o,
  output logic       busy_o
);

  uart_tx_state_t            state_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [2:0]                bit_idx_q;
  logic                      tx_q;
  logic                      ack_q;
  logic                      accept;
  logic                      bit_done;
  logic                      baud_clear;

  assign busy_o     = (state_q != IDLE);
  assign stall_o    = busy_o;
  assign accept     = cyc_i && stb_i && !stall_o;
  assign tx_o       = tx_q;
  assign ack_o      = ack_q;
  // Holding the timer cleared while idle makes every frame start at count 0.
  assign baud_clear = !busy_o;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      ack_q     <= 1'b0;
    end else begin
      ack_q <= accept;
      case (state_q)
        IDLE: begin
          if (accept && we_i) begin
            shift_q   <= dat_i;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= STOP;
            end else begin
              // tx takes the next bit in the same edge the shifter advances.
              shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_wb.sv
// Directed, table-driven bench for uart_tx_wb at four clocks per bit.
module tb_uart_tx_wb;

  localparam int unsigned CPB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       cyc   = 1'b0;
  logic       stb   = 1'b0;
  logic       we    = 1'b0;
  logic [7:0] dat   = 8'h00;
  logic       ack;
  logic       stall;
  logic       tx;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       we;
    logic [7:0] dat;
    logic [9:0] frame;  // bit i = expected tx level during UART bit i (0 = start)
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] seq_dat [4];
  logic [9:0] seq_frm [4];

  always #5 clk = ~clk;

  uart_tx_wb #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cyc_i  (cyc),
    .stb_i  (stb),
    .we_i   (we),
    .dat_i  (dat),
    .ack_o  (ack),
    .stall_o(stall),
    .tx_o   (tx),
    .busy_o (busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic req(input logic w, input logic [7:0] d);
    cyc = 1'b1;
    stb = 1'b1;
    we  = w;
    dat = d;
  endtask

  // Returns how many cycles were sampled until stall was seen low (accept cycle).
  task automatic wait_accept(output int waited);
    waited = 0;
    while (waited < 100) begin
      @(negedge clk);
      waited++;
      if (!stall) break;
    end
    if (stall) chk1("accept_timeout", stall, 1'b0);
  endtask

  // Called at the start of the cycle after accept; covers 40 frame cycles.
  task automatic check_frame(input logic [9:0] exp, input int drop_at);
    for (int j = 0; j < 10 * CPB; j++) begin
      @(negedge clk);
      chk1("frame_tx", tx, exp[j / CPB]);
      chk1("frame_ack", ack, j == 0);
      chk1("frame_stall", stall, 1'b1);
      chk1("frame_busy", busy, 1'b1);
      if (j + 1 == drop_at) cyc = 1'b0;
    end
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk1("idle_tx", tx, 1'b1);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_stall", stall, 1'b0);
      chk1("idle_ack", ack, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;

    vecs[0] = '{1'b1, 8'hA5, 10'b1101001010};
    vecs[1] = '{1'b0, 8'h3C, 10'b1111111111};
    vecs[2] = '{1'b1, 8'h55, 10'b1010101010};
    vecs[3] = '{1'b1, 8'h81, 10'b1100000010};

    seq_dat[0] = 8'h01; seq_frm[0] = 10'b1000000010;
    seq_dat[1] = 8'h02; seq_frm[1] = 10'b1000000100;
    seq_dat[2] = 8'h03; seq_frm[2] = 10'b1000000110;
    seq_dat[3] = 8'h04; seq_frm[3] = 10'b1000001000;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_ack", ack, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_check(2);

    // Single transactions from the table
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 req(vecs[i].we, vecs[i].dat);
      wait_accept(w);
      chk_int("accept_wait", w, 1);
      @(posedge clk);
      #1 begin cyc = 1'b0; stb = 1'b0; end
      if (vecs[i].we) begin
        check_frame(vecs[i].frame, 0);
        idle_check(3);
      end else begin
        @(negedge clk);
        chk1("read_ack", ack, 1'b1);
        chk1("read_tx", tx, 1'b1);
        chk1("read_busy", busy, 1'b0);
        idle_check(4);
      end
    end

    // 0x00 then 0xFF held while stalled
    @(posedge clk);
    #1 req(1'b1, 8'h00);
    wait_accept(w);
    @(posedge clk);
    #1 dat = 8'hFF;
    check_frame(10'b1000000000, 0);
    wait_accept(w);
    chk_int("b2b_gap", w, 1);
    chk1("b2b_gap_tx", tx, 1'b1);
    chk1("b2b_gap_ack", ack, 1'b0);
    @(posedge clk);
    #1 begin cyc = 1'b0; stb = 1'b0; end
    check_frame(10'b1111111110, 0);
    idle_check(3);

    // Continuous requests 0x01..0x04
    @(posedge clk);
    #1 req(1'b1, seq_dat[0]);
    for (int k = 0; k < 4; k++) begin
      wait_accept(w);
      if (k > 0) chk_int("stream_gap", w, 1);
      @(posedge clk);
      #1 begin
        if (k < 3) dat = seq_dat[k + 1];
        else begin cyc = 1'b0; stb = 1'b0; end
      end
      check_frame(seq_frm[k], 0);
    end
    idle_check(3);

    // cyc drops in frame cycle 5 of 0x0F
    @(posedge clk);
    #1 req(1'b1, 8'h0F);
    wait_accept(w);
    @(posedge clk);
    check_frame(10'b1000011110, 5);
    stb = 1'b0;
    idle_check(4);

    // Reset asserted in frame cycle 13 of 0x81 (data bit 2 = 0 on the line)
    @(posedge clk);
    #1 req(1'b1, 8'h81);
    wait_accept(w);
    @(posedge clk);
    #1 begin cyc = 1'b0; stb = 1'b0; end
    repeat (12) @(posedge clk);
    #2 chk1("pre_rst_tx", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("async_rst_tx", tx, 1'b1);
    chk1("async_rst_ack", ack, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_check(6);
    @(posedge clk);
    #1 req(1'b1, 8'h55);
    wait_accept(w);
    chk_int("post_rst_accept", w, 1);
    @(posedge clk);
    #1 begin cyc = 1'b0; stb = 1'b0; end
    check_frame(10'b1010101010, 0);
    idle_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
